// File: rtl/multiplier_grad_product_seq_pkg.sv
// ============================================================================
// Module : multiplier_grad_product_seq_pkg
// Brief  : FSM state encoding and product-index constants for the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multiplier_grad_product_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_XX = 3'd0;
    localparam idx_t IDX_XY = 3'd1;
    localparam idx_t IDX_YY = 3'd2;
    localparam idx_t IDX_XT = 3'd3;
    localparam idx_t IDX_YT = 3'd4;

endpackage

`default_nettype wire

// File: rtl/multiplier_grad_product_mul.sv
// ============================================================================
// Module : multiplier_grad_product_mul
// Brief  : Combinational signed g_width x g_width multiplier, full precision.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier_grad_product_mul #(
    parameter int g_width = 8,
    parameter int p_width = 2 * g_width
) (
    input  logic signed [g_width-1:0] a,
    input  logic signed [g_width-1:0] b,
    output logic signed [p_width-1:0] prod
);

    logic signed [2*g_width-1:0] w_a;
    logic signed [2*g_width-1:0] w_b;
    logic signed [2*g_width-1:0] w_full;

    // Sign-extend first so the product is formed at full width explicitly.
    assign w_a    = {{g_width{a[g_width-1]}}, a};
    assign w_b    = {{g_width{b[g_width-1]}}, b};
    assign w_full = w_a * w_b;
    assign prod   = p_width'(w_full);

endmodule

`default_nettype wire

// File: rtl/multiplier_grad_product_seq.sv
// ============================================================================
// Module : multiplier_grad_product_seq
// Brief  : Computes ix*ix, ix*iy, iy*iy, ix*it, iy*it on one shared multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier_grad_product_seq
    import multiplier_grad_product_seq_pkg::*;
#(
    parameter int g_width = 8,
    parameter int p_width = 2 * g_width
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic signed [g_width-1:0] ix,
    input  logic signed [g_width-1:0] iy,
    input  logic signed [g_width-1:0] it,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic signed [p_width-1:0] ixx,
    output logic signed [p_width-1:0] ixy,
    output logic signed [p_width-1:0] iyy,
    output logic signed [p_width-1:0] ixt,
    output logic signed [p_width-1:0] iyt
);

    state_t                    r_state;
    state_t                    w_next;
    idx_t                      r_idx;
    logic signed [g_width-1:0] r_ix;
    logic signed [g_width-1:0] r_iy;
    logic signed [g_width-1:0] r_it;
    logic signed [g_width-1:0] r_op_a;
    logic signed [g_width-1:0] r_op_b;
    logic                      r_op_vld;
    idx_t                      r_op_idx;
    logic signed [g_width-1:0] w_sel_a;
    logic signed [g_width-1:0] w_sel_b;
    logic signed [p_width-1:0] w_prod;
    logic signed [p_width-1:0] r_ixx;
    logic signed [p_width-1:0] r_ixy;
    logic signed [p_width-1:0] r_iyy;
    logic signed [p_width-1:0] r_ixt;
    logic signed [p_width-1:0] r_iyt;
    logic                      w_accept;

    assign in_rdy   = !reset && ((r_state == IDLE) || ((r_state == DONE) && out_rdy));
    assign w_accept = in_val && in_rdy;
    assign out_val  = (r_state == DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_val) w_next = ISSUE;
            ISSUE:   if (r_idx == IDX_YT) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    if (out_rdy) w_next = in_val ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        case (r_idx)
            IDX_XX:  begin w_sel_a = r_ix; w_sel_b = r_ix; end
            IDX_XY:  begin w_sel_a = r_ix; w_sel_b = r_iy; end
            IDX_YY:  begin w_sel_a = r_iy; w_sel_b = r_iy; end
            IDX_XT:  begin w_sel_a = r_ix; w_sel_b = r_it; end
            IDX_YT:  begin w_sel_a = r_iy; w_sel_b = r_it; end
            default: begin w_sel_a = '0;   w_sel_b = '0;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ix    <= '0;
            r_iy    <= '0;
            r_it    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ix  <= ix;
                r_iy  <= iy;
                r_it  <= it;
                r_idx <= IDX_XX;
            end else if (r_state == ISSUE) begin
                r_idx <= r_idx + idx_t'(1);
            end
        end
    end

    // Stage 1: operand register, tagged with the index it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_vld <= 1'b0;
            r_op_idx <= '0;
        end else begin
            r_op_vld <= (r_state == ISSUE);
            if (r_state == ISSUE) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_idx <= r_idx;
            end
        end
    end

    multiplier_grad_product_mul #(
        .g_width (g_width),
        .p_width (p_width)
    ) u_mul (
        .a    (r_op_a),
        .b    (r_op_b),
        .prod (w_prod)
    );

    // Stage 2: product registers, written only when a tagged operand pair lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ixx <= '0;
            r_ixy <= '0;
            r_iyy <= '0;
            r_ixt <= '0;
            r_iyt <= '0;
        end else if (r_op_vld) begin
            case (r_op_idx)
                IDX_XX:  r_ixx <= w_prod;
                IDX_XY:  r_ixy <= w_prod;
                IDX_YY:  r_iyy <= w_prod;
                IDX_XT:  r_ixt <= w_prod;
                IDX_YT:  r_iyt <= w_prod;
                default: ;
            endcase
        end
    end

    assign ixx = r_ixx;
    assign ixy = r_ixy;
    assign iyy = r_iyy;
    assign ixt = r_ixt;
    assign iyt = r_iyt;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_grad_product_seq.sv
// ============================================================================
// Module : tb_multiplier_grad_product_seq
// Brief  : Directed self-checking bench for multiplier_grad_product_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiplier_grad_product_seq;

    logic              clk;
    logic              reset;
    logic              in_val;
    logic              in_rdy;
    logic signed [7:0] ix;
    logic signed [7:0] iy;
    logic signed [7:0] it;
    logic              out_val;
    logic              out_rdy;
    logic signed [15:0] ixx;
    logic signed [15:0] ixy;
    logic signed [15:0] iyy;
    logic signed [15:0] ixt;
    logic signed [15:0] iyt;
    logic [79:0]       prods;
    logic [79:0]       exp_p;

    int vectors;
    int errors;

    assign prods = {ixx, ixy, iyy, ixt, iyt};

    multiplier_grad_product_seq #(
        .g_width (8),
        .p_width (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .ix      (ix),
        .iy      (iy),
        .it      (it),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .ixx     (ixx),
        .ixy     (ixy),
        .iyy     (iyy),
        .ixt     (ixt),
        .iyt     (iyt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // Called in cycle 0 with in_rdy expected high; returns in cycle 1.
    task automatic send(input logic signed [7:0] x, input logic signed [7:0] y,
                        input logic signed [7:0] t);
        ix     = x;
        iy     = y;
        it     = t;
        in_val = 1'b1;
        next_cycle();
        in_val = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        #2;
        vectors++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_rdy_low: got %b want 0", in_rdy);
        end
        next_cycle();
        reset = 1'b0;
        #2;
        vectors++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
        end
        vectors++;
        if (prods !== 80'h0) begin
            errors++;
            $display("FAIL reset_products: got %h want 0", prods);
        end
    endtask

    task automatic test_basic();
        out_rdy = 1'b1;
        send(8'sd3, -8'sd2, 8'sd5);
        // Scribble inputs and pulse in_val while busy; none of it may matter.
        for (int c = 1; c <= 5; c++) begin
            ix = 8'sd100; iy = -8'sd77; it = 8'sd11;
            in_val = c[0];
            next_cycle();
        end
        in_val = 1'b0;
        #2;
        vectors++;
        if (out_val !== 1'b0 || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_cycle6: out_val=%b in_rdy=%b want 0/0", out_val, in_rdy);
        end
        next_cycle();
        #2;
        exp_p = {16'sd9, -16'sd6, 16'sd4, 16'sd15, -16'sd10};
        vectors++;
        if (out_val !== 1'b1) begin
            errors++;
            $display("FAIL basic_out_val_c7: got %b want 1", out_val);
        end
        vectors++;
        if (prods !== exp_p) begin
            errors++;
            $display("FAIL basic_products: got %h want %h", prods, exp_p);
        end
        next_cycle();
        #2;
        vectors++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_cycle8: out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
        end
    endtask

    task automatic test_extremes();
        out_rdy = 1'b1;
        send(-8'sd128, -8'sd128, -8'sd128);
        wait_cycles(6);
        #2;
        exp_p = {5{16'h4000}};
        vectors++;
        if (out_val !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL extreme_neg: out_val=%b got %h want %h", out_val, prods, exp_p);
        end
        next_cycle();
        send(8'sd127, 8'sd1, -8'sd128);
        wait_cycles(6);
        #2;
        exp_p = {16'sd16129, 16'sd127, 16'sd1, -16'sd16256, -16'sd128};
        vectors++;
        if (out_val !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL extreme_mixed: out_val=%b got %h want %h", out_val, prods, exp_p);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int bad;
        out_rdy = 1'b0;
        send(8'sd7, -8'sd3, 8'sd2);
        wait_cycles(6);
        #2;
        exp_p = {16'sd49, -16'sd21, 16'sd9, 16'sd14, -16'sd6};
        vectors++;
        if (out_val !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL bp_first: out_val=%b got %h want %h", out_val, prods, exp_p);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            ix = 8'(c * 13); iy = -8'sd5; it = 8'(c);
            in_val = c[0];
            #2;
            if (out_val !== 1'b1 || in_rdy !== 1'b0 || prods !== exp_p) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles, last out_val=%b in_rdy=%b got %h want %h",
                     bad, out_val, in_rdy, prods, exp_p);
        end
        next_cycle();
        in_val  = 1'b0;
        out_rdy = 1'b1;
        #2;
        vectors++;
        if (out_val !== 1'b1 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_val=%b in_rdy=%b want 1/1", out_val, in_rdy);
        end
        next_cycle();
        #2;
        vectors++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL bp_idle: out_val=%b in_rdy=%b got %h want %h", out_val, in_rdy, prods, exp_p);
        end
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b1;
        ix = 8'sd1; iy = 8'sd2; it = 8'sd3;
        in_val = 1'b1;
        next_cycle();
        ix = -8'sd4; iy = 8'sd5; it = -8'sd6;
        wait_cycles(6);
        #2;
        exp_p = {16'sd1, 16'sd2, 16'sd4, 16'sd3, 16'sd6};
        vectors++;
        if (out_val !== 1'b1 || in_rdy !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL b2b_first: out_val=%b in_rdy=%b got %h want %h", out_val, in_rdy, prods, exp_p);
        end
        next_cycle();
        in_val = 1'b0;
        #2;
        vectors++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: out_val=%b want 0", out_val);
        end
        wait_cycles(5);
        #2;
        vectors++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle13: out_val=%b want 0", out_val);
        end
        next_cycle();
        #2;
        exp_p = {16'sd16, -16'sd20, 16'sd25, 16'sd24, -16'sd30};
        vectors++;
        if (out_val !== 1'b1 || prods !== exp_p) begin
            errors++;
            $display("FAIL b2b_second: out_val=%b got %h want %h", out_val, prods, exp_p);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int bad;
        out_rdy = 1'b1;
        send(8'sd3, -8'sd2, 8'sd5);
        wait_cycles(2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
        vectors++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0 || prods !== 80'h0) begin
            errors++;
            $display("FAIL midreset_state: in_rdy=%b out_val=%b got %h want 0", in_rdy, out_val, prods);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            #2;
            if (out_val !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_no_out: %0d cycles with out_val=1, want 0", bad);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        ix = '0; iy = '0; it = '0;
        #1;
        test_reset();
        next_cycle();
        test_basic();
        test_extremes();
        test_backpressure();
        next_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
